imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory image from a byte stream, for example a UART receiver, in place of a file preload. Bytes are packed little-endian into 32-bit words: the first byte goes to bits 7:0 and the fourth to bits 31:24. This matches how the fetch path reassembles instructions from consecutive byte addresses. The loader keeps the CPU held while a load is in progress.

## Interface
Parameters:
- MEM_BYTES, 472: size of the instruction memory in bytes; bounds check limit.
- LEN_W, 16: width of the byte-count input.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  32  byte address of first byte; must be word-aligned.
- length  in  LEN_W  number of bytes to load.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  32  word-aligned byte address of the write.
- mem_wdata  out  32  packed word.
- mem_be  out  4  byte enables; bit i covers mem_wdata[8i+7:8i].
- cpu_hold  out  1  CPU stall/reset request during load.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag.

## Operation
- A byte is accepted when s_valid and s_ready are both high.
- FSM states and transitions:
  - IDLE: start=1 → check arguments.
    - base_addr[1:0] != 0, or base_addr + length > MEM_BYTES (computed in 33 bits) → ERR.
    - length == 0 → DONE.
    - Otherwise → LOAD.
  - LOAD: s_ready=1. Each accepted byte goes into lane cnt[1:0] of the pack buffer, and cnt increments.
    - Lane 3 filled, or last byte accepted → register mem_addr = base_addr + (word index × 4), mem_wdata, and mem_be (lanes filled), then assert mem_we next cycle. Unfilled lanes carry 0.
    - Last byte accepted → FLUSH; otherwise stay in LOAD.
  - FLUSH: s_ready=0; final write cycle → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: err=1, no writes → IDLE next cycle. err stays set until the next start or reset.
- start is ignored outside IDLE.
- Output levels by state:
  - busy=1 and cpu_hold=1 in LOAD and FLUSH.
  - busy=0 and cpu_hold=0 in DONE, IDLE and ERR.
- Reset values: all outputs 0, state IDLE. Byte count and pack buffer are cleared.
- Reset mid-load:
  - The partial word is discarded.
  - No further mem_we is issued; a write registered in that cycle is dropped.
  - Words already written remain in memory.

## Timing
- start at edge 0 → LOAD from cycle 1: s_ready=1, busy=1, cpu_hold=1.
- A byte that completes a word, accepted at edge k → mem_we=1 during cycle k+1 only.
- s_ready stays high during non-final write cycles, giving a 1 byte/cycle sustained rate.
- Last byte accepted at edge k:
  - cycle k+1: FLUSH with mem_we.
  - cycle k+2: done=1, busy=0, cpu_hold=0.
- Length-0 load: done at cycle 1, no mem_we.
- Error case: err=1 from cycle 1, and busy never asserts.
- Backpressure: s_valid gaps stall the byte count with no effect on contents. mem_we never fires twice for the same word.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DONE, ERR);
  - the default MEM_BYTES constant, which the instruction memory also uses.
- One sub-module, imem_byte_packer, handles lane placement, byte-enable accumulation and the word-complete flag. The FSM, address counter and bounds check stay in imem_loader.

## Test plan
- Full words: base 0, length 8, bytes 93 00 50 00 13 01 A0 00 → two writes:
  - addr 0x0, data 0x00500093, be 0xF;
  - addr 0x4, data 0x00A00113, be 0xF;
  - then one done pulse and cpu_hold low.
- Partial tail: base 0x10, length 6 → second write at addr 0x14 with be 0x3, upper bytes of mem_wdata = 0.
- Backpressure: random s_valid gaps on a 12-byte load → identical three writes and addresses, no duplicate mem_we.
- Bad arguments, each giving err=1, no mem_we and busy never high:
  - base 0x2 with any length;
  - base 468, length 8 with MEM_BYTES=472.
- Length 0 → done at cycle 1, no writes, err=0.
- Reset asserted after 5 of 8 bytes → all outputs 0 the next cycle, no further writes, no done. A following start loads normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_e;

  // Instruction memory size in bytes; the memory itself sizes from this too.
  localparam int unsigned MEM_BYTES_DEFAULT = 472;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    lane_mask = 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a source (e.g. UART receiver) and the loader.
interface imem_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/imem_byte_packer.sv
// Packs bytes little-endian into a 32-bit word and tracks which lanes are filled.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        complete_o
);

  logic [31:0] buf_q, buf_d;
  logic [3:0]  be_q, be_d;

  // word_o/be_o already include the byte arriving this cycle so the caller
  // can register the finished word on the same edge that accepts the byte.
  always_comb begin
    buf_d = buf_q;
    be_d  = be_q;
    if (byte_vld_i) begin
      buf_d[{lane_i, 3'b000} +: 8] = byte_i;
      be_d = be_q | lane_mask(lane_i);
    end
  end

  assign complete_o = byte_vld_i && ((lane_i == 2'd3) || last_i);
  assign word_o     = buf_d;
  assign be_o       = be_d;

  always_ff @(posedge clk) begin
    if (reset || clear_i || complete_o) begin
      buf_q <= '0;
      be_q  <= '0;
    end else begin
      buf_q <= buf_d;
      be_q  <= be_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream, holding the CPU while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  imem_loader_if.slave     strm,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, cnt_q;
  logic [31:0]      waddr_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic             err_q;

  logic        start_idle, accept, last_byte, args_bad;
  logic [32:0] end_addr;
  logic [31:0] pack_word;
  logic [3:0]  pack_be;
  logic        pack_complete;

  assign end_addr   = {1'b0, base_addr} + 33'(length);
  assign args_bad   = (base_addr[1:0] != 2'b00) || (end_addr > 33'(MEM_BYTES));
  assign start_idle = (state_q == ST_IDLE) && start;
  assign strm.s_ready = (state_q == ST_LOAD);
  assign accept     = strm.s_valid && strm.s_ready;
  assign last_byte  = (cnt_q == len_q - LEN_W'(1));

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (start_idle),
    .byte_vld_i (accept),
    .lane_i     (cnt_q[1:0]),
    .byte_i     (strm.s_data),
    .last_i     (last_byte),
    .word_o     (pack_word),
    .be_o       (pack_be),
    .complete_o (pack_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (args_bad)            state_d = ST_ERR;
          else if (length == '0)   state_d = ST_DONE;
          else                     state_d = ST_LOAD;
        end
      end
      ST_LOAD:  if (accept && last_byte) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // err_q is reloaded on every accepted start, so a good start clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= pack_complete;
      if (start_idle) begin
        len_q   <= length;
        cnt_q   <= '0;
        waddr_q <= base_addr;
        err_q   <= args_bad;
      end
      if (accept) cnt_q <= cnt_q + LEN_W'(1);
      if (pack_complete) begin
        mem_addr_q  <= waddr_q;
        mem_wdata_q <= pack_word;
        mem_be_q    <= pack_be;
        waddr_q     <= waddr_q + 32'd4;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign cpu_hold  = busy;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a word-level write model and per-cycle compare.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned LEN_W = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] length;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;

  imem_loader_if strm ();

  imem_loader #(.MEM_BYTES(472), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .strm      (strm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  int unsigned done_cnt = 0;
  bit          busy_seen = 1'b0;
  logic [7:0]  stim [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: every write strobe must match the next expected word.
  always @(negedge clk) begin
    wr_t e;
    wr_t o;
    if (busy) busy_seen = 1'b1;
    if (done) done_cnt++;
    chk("hold_vs_busy", {31'b0, cpu_hold}, {31'b0, busy});
    if (mem_we === 1'b1) begin
      o.addr = mem_addr; o.data = mem_wdata; o.be = mem_be;
      obs_q.push_back(o);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_be", {28'b0, mem_be}, {28'b0, e.be});
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic pulse_start(input logic [31:0] b, input int unsigned len);
    start = 1'b1; base_addr = b; length = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    strm.s_valid = 1'b1; strm.s_data = b;
    while (!strm.s_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL byte_wait: actual s_ready=0 required s_ready=1 within 50 cycles");
    end
    @(posedge clk); #1;
    strm.s_valid = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] base, input int unsigned len,
                          input bit gaps, input int unsigned stop_after);
    int unsigned fed = (stop_after < len) ? stop_after : len;
    logic [31:0] w = '0;
    logic [3:0]  be = '0;
    wr_t         x;
    int unsigned g;
    int unsigned d0;
    for (int unsigned i = 0; i < fed; i++) begin
      w  = w | (32'(stim[i]) << (8 * (i % 4)));
      be = be | 4'(1 << (i % 4));
      if ((i % 4 == 3) || (i == len - 1)) begin
        x.addr = base + 32'(4 * (i / 4)); x.data = w; x.be = be;
        exp_q.push_back(x);
        w = '0; be = '0;
      end
    end
    obs_q.delete();
    pulse_start(base, len);
    chk("c1_busy", {31'b0, busy}, 32'd1);
    chk("c1_ready", {31'b0, strm.s_ready}, 32'd1);
    chk("c1_err", {31'b0, err}, 32'd0);
    for (int unsigned i = 0; i < fed; i++) begin
      if (gaps) begin
        g = (i == 5) ? 1 : $urandom_range(0, 2);
        for (int unsigned j = 0; j < g; j++) begin
          if (i == 5 && j == 0) begin
            start = 1'b1; base_addr = 32'h100; length = LEN_W'(4);
          end
          @(posedge clk); #1;
          start = 1'b0; base_addr = base;
        end
      end
      send_byte(stim[i]);
      chk("we_timing", {31'b0, mem_we}, {31'b0, ((i % 4 == 3) || (i == len - 1))});
    end
    if (fed == len) begin
      chk("flush_ready", {31'b0, strm.s_ready}, 32'd0);
      chk("flush_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("done_busy", {31'b0, busy}, 32'd0);
      chk("done_hold", {31'b0, cpu_hold}, 32'd0);
      chk("done_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk); #1;
      chk("done_once", {31'b0, done}, 32'd0);
    end else begin
      d0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hold", {31'b0, cpu_hold}, 32'd0);
      chk("rst_ready", {31'b0, strm.s_ready}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_data", mem_wdata, 32'd0);
      chk("rst_be", {28'b0, mem_be}, 32'd0);
      repeat (4) begin @(posedge clk); #1; end
      chk("rst_no_done", done_cnt, d0);
    end
    chk("exp_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run_err(input logic [31:0] base, input int unsigned len);
    busy_seen = 1'b0;
    obs_q.delete();
    pulse_start(base, len);
    chk("err_c1", {31'b0, err}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd0);
    chk("err_ready", {31'b0, strm.s_ready}, 32'd0);
    @(posedge clk); #1;
    chk("err_sticky", {31'b0, err}, 32'd1);
    chk("err_no_done", {31'b0, done}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("err_busy_never", {31'b0, busy_seen}, 32'd0);
    chk("err_no_write", obs_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    strm.s_valid = 1'b0; strm.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we", {31'b0, mem_we}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full words.
    stim[0] = 8'h93; stim[1] = 8'h00; stim[2] = 8'h50; stim[3] = 8'h00;
    stim[4] = 8'h13; stim[5] = 8'h01; stim[6] = 8'hA0; stim[7] = 8'h00;
    run_load(32'h0, 8, 1'b0, 99);
    chk("t1_count", obs_q.size(), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("t1_w0_addr", obs_q[0].addr, 32'h0);
      chk("t1_w0_data", obs_q[0].data, 32'h00500093);
      chk("t1_w0_be", {28'b0, obs_q[0].be}, 32'hF);
      chk("t1_w1_addr", obs_q[1].addr, 32'h4);
      chk("t1_w1_data", obs_q[1].data, 32'h00A00113);
    end

    // Partial tail.
    for (int unsigned i = 0; i < 6; i++) stim[i] = 8'(8'h11 * (i + 1));
    run_load(32'h10, 6, 1'b0, 99);
    chk("t2_count", obs_q.size(), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("t2_w0_data", obs_q[0].data, 32'h44332211);
      chk("t2_w1_addr", obs_q[1].addr, 32'h14);
      chk("t2_w1_data", obs_q[1].data, 32'h00006655);
      chk("t2_w1_be", {28'b0, obs_q[1].be}, 32'h3);
    end

    // Backpressure, with a stray start during the load.
    for (int unsigned i = 0; i < 12; i++) stim[i] = 8'(i * 17 + 3);
    run_load(32'h40, 12, 1'b1, 99);
    chk("t3_count", obs_q.size(), 32'd3);
    if (obs_q.size() >= 3) chk("t3_w2_addr", obs_q[2].addr, 32'h48);

    // Exactly reaches the end of memory.
    run_load(32'd468, 4, 1'b0, 99);
    chk("t4_count", obs_q.size(), 32'd1);

    run_err(32'h2, 4);
    run_err(32'd468, 8);

    // Length zero also clears the sticky error.
    obs_q.delete();
    busy_seen = 1'b0;
    pulse_start(32'h80, 0);
    chk("z_done", {31'b0, done}, 32'd1);
    chk("z_err", {31'b0, err}, 32'd0);
    chk("z_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("z_done_once", {31'b0, done}, 32'd0);
    chk("z_no_write", obs_q.size(), 32'd0);
    chk("z_busy_never", {31'b0, busy_seen}, 32'd0);

    // Reset after 5 of 8 bytes, then a normal reload.
    for (int unsigned i = 0; i < 8; i++) stim[i] = 8'(8'hA0 + i);
    run_load(32'h20, 8, 1'b0, 5);
    chk("t6_count", obs_q.size(), 32'd1);
    run_load(32'h20, 8, 1'b0, 99);
    chk("t7_count", obs_q.size(), 32'd2);
    if (obs_q.size() >= 2) chk("t7_w1_data", obs_q[1].data, 32'hA7A6A5A4);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
